// File: rtl/mips32_register_file.sv
// mips32_register_file
// General-purpose register file for the single-cycle MIPS32 datapath.
// Two combinational read ports (rs, rt) feed the ALU; one write port takes
// the write-back value on the rising clock edge. Entry 0 is hardwired to zero.
// With BYPASS=1 a write in flight is forwarded to any read port addressing
// the same non-zero index, so the value is usable in the cycle it is written.
// While rst_n is low both read ports are forced to zero, bypass included.
module mips32_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 exists in the array but is never written after reset; reads of
  // index 0 are additionally forced to zero so it cannot leak anything.
  logic [DATA_W-1:0] r_regs [0:NREG-1];

  logic              w_wr_en;
  logic              w_bypass_en;
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_stored1;
  logic [DATA_W-1:0] w_stored2;

  assign w_wr_en     = reg_write && (write_reg != '0);
  assign w_bypass_en = (BYPASS != 0);

  // Storage: async clear on reset, one qualified write per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Stored-value lookup per port, with index 0 pinned to zero.
  always_comb begin
    w_stored1 = '0;
    w_stored2 = '0;
    if (read_reg1 != '0) begin
      w_stored1 = r_regs[read_reg1];
    end
    if (read_reg2 != '0) begin
      w_stored2 = r_regs[read_reg2];
    end
  end

  // Each port decides independently whether the in-flight write targets it.
  always_comb begin
    w_hit1 = w_bypass_en && w_wr_en && (write_reg == read_reg1);
    w_hit2 = w_bypass_en && w_wr_en && (write_reg == read_reg2);
  end

  // Output select: reset forces zero, then bypass, then stored entry.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (rst_n) begin
      read_data1 = w_hit1 ? write_data : w_stored1;
      read_data2 = w_hit2 ? write_data : w_stored2;
    end
  end

endmodule
